programmable_pulse_generator: RTL and testbench

Runtime-programmable successor to the fixed-rate pulse generator. Emits pulses with a programmable period and high width, in either free-running periodic mode or triggered one-shot mode, with glitch-free period/width reloads at period boundaries. Sits between the clock domain's control logic and consumers such as counter-advance strobes and display or scan ticks.

---
 rtl/pulse_gen_pkg.sv | 9 +
 rtl/pulse_width_stretcher.sv | 35 +++
 rtl/programmable_pulse_generator.sv | 96 +++++++++
 tb/tb_programmable_pulse_generator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state and mode encodings for the programmable pulse generator
package pulse_gen_pkg;
    typedef enum logic [0:0] {
        PG_IDLE = 1'b0,
        PG_RUN  = 1'b1
    } pg_state_e;
    localparam logic PG_MODE_PERIODIC = 1'b0;
    localparam logic PG_MODE_ONESHOT  = 1'b1;
endpackage

// File: rtl/pulse_width_stretcher.sv
// pulse_width_stretcher: holds o_out high for i_load_val cycles after each start strobe
module pulse_width_stretcher #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_out
);
    logic [WIDTH-1:0] r_cnt;
    logic             r_out;
    logic             w_load_nz;
    logic             w_cnt_nz;
    assign w_load_nz = i_load_val != '0;
    assign w_cnt_nz  = r_cnt != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_start) begin
            // a start while still high just reloads, so overlapping pulses merge into one
            r_cnt <= w_load_nz ? i_load_val - WIDTH'(1) : '0;
            r_out <= w_load_nz;
        end else begin
            r_cnt <= w_cnt_nz ? r_cnt - WIDTH'(1) : '0;
            r_out <= w_cnt_nz;
        end
    end
    assign o_out = r_out;
endmodule

// File: rtl/programmable_pulse_generator.sv
// programmable_pulse_generator: periodic / one-shot pulse source with period-boundary reloads
module programmable_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int          WIDTH          = 16,
    parameter int unsigned DEFAULT_PERIOD = 1,
    parameter int unsigned DEFAULT_HIGH   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             trigger,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             out,
    output logic             tick,
    output logic             busy
);
    pg_state_e        r_state;
    logic             r_mode;
    logic             r_tick;
    logic             r_pend_v;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_p_act;
    logic [WIDTH-1:0] r_h_act;
    logic [WIDTH-1:0] r_p_pend;
    logic [WIDTH-1:0] r_h_pend;
    logic             w_run;
    logic             w_at_top;
    logic             w_start;
    logic             w_out;
    logic [WIDTH-1:0] w_h_next;
    assign w_run    = (r_state == PG_RUN) && enable;
    assign w_at_top = w_run && (r_cnt == r_p_act);
    assign w_start  = enable && (r_state == PG_IDLE) &&
                      ((mode == PG_MODE_PERIODIC) || (trigger && !busy));
    // width used by the pulse that begins the next period, so a reload applies to it too
    assign w_h_next = load ? high_in : r_pend_v ? r_h_pend : r_h_act;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PG_IDLE;
            r_mode  <= PG_MODE_PERIODIC;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_at_top;
            if (!enable) begin
                r_state <= PG_IDLE;
                r_cnt   <= '0;
            end else if (r_state == PG_IDLE) begin
                r_cnt <= '0;
                if (w_start) begin
                    r_state <= PG_RUN;
                    r_mode  <= mode;
                end
            end else begin
                r_cnt <= w_at_top ? '0 : r_cnt + WIDTH'(1);
                if (w_at_top && r_mode == PG_MODE_ONESHOT) r_state <= PG_IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_act  <= WIDTH'(DEFAULT_PERIOD);
            r_h_act  <= WIDTH'(DEFAULT_HIGH);
            r_p_pend <= WIDTH'(DEFAULT_PERIOD);
            r_h_pend <= WIDTH'(DEFAULT_HIGH);
            r_pend_v <= 1'b0;
        end else if (load && (r_state == PG_IDLE || w_at_top)) begin
            r_p_act  <= period_in;
            r_h_act  <= high_in;
            r_pend_v <= 1'b0;
        end else if (load) begin
            r_p_pend <= period_in;
            r_h_pend <= high_in;
            r_pend_v <= 1'b1;
        end else if (w_at_top && r_pend_v) begin
            r_p_act  <= r_p_pend;
            r_h_act  <= r_h_pend;
            r_pend_v <= 1'b0;
        end
    end
    pulse_width_stretcher #(.WIDTH(WIDTH)) u_stretch (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_at_top),
        .i_clear    (!enable),
        .i_load_val (w_h_next),
        .o_out      (w_out)
    );
    assign out  = w_out;
    assign tick = r_tick;
    assign busy = (r_state == PG_RUN) || w_out;
endmodule

// File: tb/tb_programmable_pulse_generator.sv
// tb_programmable_pulse_generator: randomized self-checking bench with a period-level reference model
module tb_programmable_pulse_generator;
    localparam int W = 16;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic         trigger = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] period_in = '0;
    logic [W-1:0] high_in = '0;
    logic         out;
    logic         tick;
    logic         busy;
    int           errors = 0;
    int           checks = 0;

    programmable_pulse_generator #(.WIDTH(W), .DEFAULT_PERIOD(1), .DEFAULT_HIGH(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .trigger(trigger),
        .load(load), .period_in(period_in), .high_in(high_in),
        .out(out), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out, tick, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_assert out/tick/busy=%b expected 000", {out, tick, busy});
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out, tick, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release out/tick/busy=%b expected 000", {out, tick, busy});
        end
    endtask

    // Periodic run started in interval 0. Optional reload(s) in RUN at intervals tl1/tl2 (0 = none);
    // tl2 carries the values that must win.
    task automatic run_periodic(input int p, input int h, input int p2, input int h2,
                                input int tl1, input int tl2, input int n,
                                input bit init_load, input string name);
        bit eo [0:255];
        bit et [0:255];
        int t;
        int top;
        int cp;
        int ch;
        bit pend;
        for (int i = 0; i < 256; i++) begin
            eo[i] = 1'b0;
            et[i] = 1'b0;
        end
        t = 1;
        cp = p;
        ch = h;
        pend = tl2 > 0;
        while (t <= n) begin
            top = t + cp;
            if (pend && tl2 <= top) begin
                cp = p2;
                ch = h2;
                pend = 1'b0;
            end
            if (top + 1 <= n) et[top+1] = 1'b1;
            for (int i = 0; i < ch; i++) if (top + 1 + i <= n) eo[top+1+i] = 1'b1;
            t = top + 1;
        end
        enable = 1'b0;
        mode = 1'b0;
        trigger = 1'b0;
        if (init_load) begin
            load = 1'b1;
            period_in = W'(p);
            high_in = W'(h);
            next_cycle();
            load = 1'b0;
        end
        enable = 1'b1;
        for (int i = 1; i <= n; i++) begin
            next_cycle();
            load = (i == tl1 && tl1 != tl2) || (i == tl2 && tl2 > 0);
            period_in = (i == tl2) ? W'(p2) : W'(p2 + 3);
            high_in = (i == tl2) ? W'(h2) : W'(h2 + 1);
            @(negedge clk);
            checks++;
            if ({out, tick, busy} !== {eo[i], et[i], 1'b1}) begin
                errors++;
                $display("FAIL %s t=%0d out/tick/busy=%b expected %b", name, i,
                         {out, tick, busy}, {eo[i], et[i], 1'b1});
            end
        end
        load = 1'b0;
        next_cycle();
        enable = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out, tick, busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s_disable out/tick/busy=%b expected 000", name, {out, tick, busy});
        end
    endtask

    task automatic test_periodic();
        run_periodic(1, 1, 0, 0, 0, 0, 16, 1'b1, "periodic_p1h1");
        run_periodic(4, 2, 0, 0, 0, 0, 20, 1'b1, "periodic_p4h2");
        for (int k = 0; k < 4; k++)
            run_periodic($urandom_range(0, 6), $urandom_range(0, 9), 0, 0, 0, 0, 40, 1'b1,
                         "periodic_rand");
    endtask

    task automatic test_reload();
        int p;
        int tl2;
        run_periodic(4, 2, 2, 1, 0, 8, 30, 1'b1, "reload_mid");
        run_periodic(4, 2, 1, 1, 0, 10, 30, 1'b1, "reload_at_top");
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 6);
            tl2 = p + 2 + $urandom_range(0, p);
            run_periodic(p, $urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 8),
                         p + 2, tl2, 50, 1'b1, "reload_rand");
        end
    endtask

    task automatic test_edge_values();
        run_periodic(0, 1, 0, 0, 0, 0, 12, 1'b1, "p0_h1");
        run_periodic(3, 0, 0, 0, 0, 0, 20, 1'b1, "h0");
        run_periodic(2, 5, 0, 0, 0, 0, 20, 1'b1, "overlap_p2h5");
    endtask

    task automatic test_oneshot(input int p, input int h, input int stray, input string name);
        int b;
        int n;
        int s1;
        int s;
        bit eo;
        bit et;
        bit eb;
        b = (h > 0) ? p + 1 + h : p + 1;
        s1 = b + 1;
        n = s1 + b + 2;
        enable = 1'b0;
        mode = 1'b1;
        load = 1'b1;
        period_in = W'(p);
        high_in = W'(h);
        next_cycle();
        load = 1'b0;
        enable = 1'b1;
        trigger = 1'b1;
        for (int i = 1; i <= n; i++) begin
            next_cycle();
            trigger = (i == stray) || (i == s1);
            @(negedge clk);
            eo = 1'b0;
            et = 1'b0;
            eb = 1'b0;
            for (int k = 0; k < 2; k++) begin
                s = (k == 0) ? 0 : s1;
                if (i >= s + p + 2 && i < s + p + 2 + h) eo = 1'b1;
                if (i == s + p + 2) et = 1'b1;
                if (i > s && i <= s + b) eb = 1'b1;
            end
            checks++;
            if ({out, tick, busy} !== {eo, et, eb}) begin
                errors++;
                $display("FAIL %s t=%0d out/tick/busy=%b expected %b", name, i,
                         {out, tick, busy}, {eo, et, eb});
            end
        end
        trigger = 1'b0;
        enable = 1'b0;
        next_cycle();
    endtask

    task automatic test_oneshot_all();
        int p;
        int h;
        test_oneshot(3, 2, 3, "oneshot_p3h2");
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 5);
            h = $urandom_range(0, 5);
            test_oneshot(p, h, $urandom_range(1, (h > 0) ? p + 1 + h : p + 1), "oneshot_rand");
        end
    endtask

    task automatic test_abort();
        bit e;
        enable = 1'b0;
        mode = 1'b0;
        load = 1'b1;
        period_in = W'(6);
        high_in = W'(4);
        next_cycle();
        load = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            @(negedge clk);
            e = (i == 8 || i == 9);
            checks++;
            if ({out, tick, busy} !== {e, i == 8, 1'b1}) begin
                errors++;
                $display("FAIL abort_run t=%0d out/tick/busy=%b expected %b", i,
                         {out, tick, busy}, {e, i == 8, 1'b1});
            end
        end
        enable = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out, tick, busy} !== 3'b000) begin
            errors++;
            $display("FAIL abort_cut out/tick/busy=%b expected 000", {out, tick, busy});
        end
        enable = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({out, tick, busy} !== 3'b000) begin
                errors++;
                $display("FAIL abort_idle out/tick/busy=%b expected 000", {out, tick, busy});
            end
        end
        mode = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            @(negedge clk);
            e = (i >= 8);
            checks++;
            if ({out, tick, busy} !== {e, i == 8, 1'b1}) begin
                errors++;
                $display("FAIL abort_restart t=%0d out/tick/busy=%b expected %b", i,
                         {out, tick, busy}, {e, i == 8, 1'b1});
            end
        end
        enable = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_run();
        bit e;
        enable = 1'b0;
        mode = 1'b0;
        load = 1'b1;
        period_in = W'(3);
        high_in = W'(3);
        next_cycle();
        load = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            @(negedge clk);
            e = (i == 5);
            checks++;
            if ({out, tick, busy} !== {e, e, 1'b1}) begin
                errors++;
                $display("FAIL rst_run t=%0d out/tick/busy=%b expected %b", i,
                         {out, tick, busy}, {e, e, 1'b1});
            end
        end
        next_cycle();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out, tick, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_run out/tick/busy=%b expected 000", {out, tick, busy});
        end
        next_cycle();
        enable = 1'b0;
        rst_n = 1'b1;
        next_cycle();
        run_periodic(1, 1, 0, 0, 0, 0, 12, 1'b0, "rst_defaults");
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reload();
        test_edge_values();
        test_oneshot_all();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
